seg_scan_decoder: RTL

- Receive-side counterpart of the hex-to-seven-segment encoder: samples a multiplexed, active-low seven-segment display bus, carrying digit enables plus segments.
- Waits for each digit's glyph to be stable, decodes it back to a 4-bit hex nibble, and assembles a full multi-digit word.
- Used on the capture/loopback side of the display path to check the display driver and the encoder end to end.

---
 rtl/seg_scan_decoder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// Capture-side decoder for a multiplexed active-low seven-segment bus.
// Waits for each digit glyph to settle, decodes it to hex and assembles full words.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [6:0]                    seg_n,
    input  logic [NUM_DIGITS-1:0]         an_n,
    output logic [4*NUM_DIGITS-1:0]       value,
    output logic                          frame_valid,
    output logic                          digit_stb,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic [3:0]                    digit_nib,
    output logic                          err
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int ZC_W  = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   s_an_q, prev_an_q;
    logic [6:0]              s_seg_q, prev_seg_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d, seen_cap;
    logic [4*NUM_DIGITS-1:0] store_q, store_d, value_q, value_d;
    logic                    frame_valid_q, digit_stb_q, err_q;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d, act_idx;
    logic [3:0]              digit_nib_q, digit_nib_d, dec_nib;
    logic [ZC_W-1:0]         zero_cnt;
    logic                    active, changed, fire, dec_ok, cap, bad, frame_done;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // A digit is active only when exactly one enable is asserted.
    always_comb begin
        act_idx  = '0;
        zero_cnt = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!s_an_q[i]) begin
                zero_cnt = zero_cnt + 1'b1;
                act_idx  = IDX_W'(i);
            end
        end
    end

    assign active          = (zero_cnt == ZC_W'(1));
    assign {dec_ok, dec_nib} = decode(~s_seg_q);

    always_comb begin
        changed = (s_an_q != prev_an_q) || (s_seg_q != prev_seg_q);
        if (changed || !active) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The changed term lets a single-sample threshold fire on the first new sample.
    assign fire = active && (cnt_d == CNT_FIRE) && (changed || (cnt_q != CNT_FIRE));
    assign cap  = fire && dec_ok;
    assign bad  = fire && !dec_ok;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic hit;
            assign hit                = cap && (act_idx == IDX_W'(gi));
            assign seen_cap[gi]       = seen_q[gi] | hit;
            assign store_d[4*gi +: 4] = hit ? dec_nib : store_q[4*gi +: 4];
        end
    endgenerate

    assign frame_done  = cap && (&seen_cap);
    assign seen_d      = frame_done ? '0 : seen_cap;
    assign value_d     = frame_done ? store_d : value_q;
    assign digit_idx_d = fire ? act_idx : digit_idx_q;
    assign digit_nib_d = cap ? dec_nib : digit_nib_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_an_q        <= '1;
            s_seg_q       <= '1;
            prev_an_q     <= '1;
            prev_seg_q    <= '1;
            cnt_q         <= '0;
            seen_q        <= '0;
            store_q       <= '0;
            value_q       <= '0;
            frame_valid_q <= 1'b0;
            digit_stb_q   <= 1'b0;
            err_q         <= 1'b0;
            digit_idx_q   <= '0;
            digit_nib_q   <= '0;
        end else begin
            s_an_q        <= an_n;
            s_seg_q       <= seg_n;
            prev_an_q     <= s_an_q;
            prev_seg_q    <= s_seg_q;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            store_q       <= store_d;
            value_q       <= value_d;
            frame_valid_q <= frame_done;
            digit_stb_q   <= cap;
            err_q         <= bad;
            digit_idx_q   <= digit_idx_d;
            digit_nib_q   <= digit_nib_d;
        end
    end

    assign value       = value_q;
    assign frame_valid = frame_valid_q;
    assign digit_stb   = digit_stb_q;
    assign err         = err_q;
    assign digit_idx   = digit_idx_q;
    assign digit_nib   = digit_nib_q;
endmodule
